// File: rtl/toy_fetch_ibuf.sv
// toy_fetch_ibuf: instruction buffer between the BPU reorder buffer and decode.
// Splits each accepted fetch packet into INST_PER_FETCH slots, stores them in a
// circular queue and presents up to DEC_WIDTH oldest instructions per cycle.
//
// Ports:
//   clk, rst       clock; asynchronous active-high reset
//   filter_vld/rdy fetch packet handshake; filter_pld holds the packet, slot 0 oldest
//   fe_ctrl_flush  front-end flush, empties the buffer on the next edge
//   dec_vld        per-lane valid (thermometer coded), dec_inst lane data
//   dec_rdy        decode consumes every valid lane this cycle
//   ibuf_cnt       current occupancy
//
// FETCH_DATA_WIDTH must equal INST_PER_FETCH*INST_WIDTH, IBUF_DEPTH must be a
// power of two and >= 2*INST_PER_FETCH, and DEC_WIDTH <= INST_PER_FETCH.
module toy_fetch_ibuf #(
    parameter int unsigned INST_WIDTH       = 32,
    parameter int unsigned INST_PER_FETCH   = 4,
    parameter int unsigned FETCH_DATA_WIDTH = 128,
    parameter int unsigned IBUF_DEPTH       = 16,
    parameter int unsigned DEC_WIDTH        = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              filter_vld,
    output logic                              filter_rdy,
    input  logic [FETCH_DATA_WIDTH-1:0]       filter_pld,
    input  logic                              fe_ctrl_flush,
    output logic [DEC_WIDTH-1:0]              dec_vld,
    output logic [DEC_WIDTH*INST_WIDTH-1:0]   dec_inst,
    input  logic                              dec_rdy,
    output logic [$clog2(IBUF_DEPTH):0]       ibuf_cnt
);

    localparam int unsigned IdxW = $clog2(IBUF_DEPTH);
    localparam int unsigned PtrW = IdxW + 1;

    logic [INST_WIDTH-1:0] mem_q [IBUF_DEPTH];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] cnt_q, cnt_d;
    logic [PtrW-1:0] deq_n;
    logic            enq;

    // Handshake and decode view depend only on registered state plus flush.
    always_comb begin
        filter_rdy = ~rst && ~fe_ctrl_flush &&
                     (cnt_q <= PtrW'(IBUF_DEPTH - INST_PER_FETCH));
        enq        = filter_vld && filter_rdy;
        deq_n      = '0;
        dec_vld    = '0;
        dec_inst   = '0;
        for (int k = 0; k < DEC_WIDTH; k++) begin
            dec_vld[k] = (cnt_q > PtrW'(k)) && ~fe_ctrl_flush;
            dec_inst[k*INST_WIDTH +: INST_WIDTH] = mem_q[rd_ptr_q[IdxW-1:0] + IdxW'(k)];
            if (dec_rdy && dec_vld[k]) begin
                deq_n = deq_n + PtrW'(1);
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (fe_ctrl_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + (enq ? PtrW'(INST_PER_FETCH) : '0);
            rd_ptr_d = rd_ptr_q + deq_n;
            cnt_d    = cnt_q + (enq ? PtrW'(INST_PER_FETCH) : '0) - deq_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Array is not reset or flushed; occupancy alone defines valid entries.
    always_ff @(posedge clk) begin
        if (enq) begin
            for (int k = 0; k < INST_PER_FETCH; k++) begin
                mem_q[wr_ptr_q[IdxW-1:0] + IdxW'(k)] <= filter_pld[k*INST_WIDTH +: INST_WIDTH];
            end
        end
    end

    assign ibuf_cnt = cnt_q;

    cnt_bound_a: assert property (@(posedge clk) disable iff (rst)
        cnt_q <= PtrW'(IBUF_DEPTH));
    ptr_cnt_a: assert property (@(posedge clk) disable iff (rst)
        cnt_q == PtrW'(wr_ptr_q - rd_ptr_q));

endmodule

// File: tb/tb_toy_fetch_ibuf.sv
module tb_toy_fetch_ibuf;

    logic         clk = 1'b0;
    logic         rst;
    logic         filter_vld, filter_rdy, fe_ctrl_flush, dec_rdy;
    logic [127:0] filter_pld;
    logic [1:0]   dec_vld;
    logic [63:0]  dec_inst;
    logic [4:0]   ibuf_cnt;

    // Second instance with three lanes so that odd occupancy is reachable.
    logic         f3_vld, f3_rdy, fl3, d3_rdy;
    logic [127:0] f3_pld;
    logic [2:0]   d3_vld;
    logic [95:0]  d3_inst;
    logic [4:0]   cnt3;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    toy_fetch_ibuf dut (
        .clk(clk), .rst(rst), .filter_vld(filter_vld), .filter_rdy(filter_rdy),
        .filter_pld(filter_pld), .fe_ctrl_flush(fe_ctrl_flush), .dec_vld(dec_vld),
        .dec_inst(dec_inst), .dec_rdy(dec_rdy), .ibuf_cnt(ibuf_cnt)
    );

    toy_fetch_ibuf #(.DEC_WIDTH(3)) dut3 (
        .clk(clk), .rst(rst), .filter_vld(f3_vld), .filter_rdy(f3_rdy),
        .filter_pld(f3_pld), .fe_ctrl_flush(fl3), .dec_vld(d3_vld),
        .dec_inst(d3_inst), .dec_rdy(d3_rdy), .ibuf_cnt(cnt3)
    );

    typedef struct {
        logic        vld;
        logic [31:0] base;
        logic        flush;
        logic        rdy;
        logic [4:0]  cnt;
        logic [1:0]  dvld;
        logic [31:0] l0;
        logic [31:0] l1;
        logic        frdy;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [127:0] pkt(input logic [31:0] b);
        return {b + 32'd3, b + 32'd2, b + 32'd1, b};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [127:0] p, input logic fl, input logic r);
        filter_vld    = v;
        filter_pld    = p;
        fe_ctrl_flush = fl;
        dec_rdy       = r;
    endtask

    logic [31:0] q[$];
    logic [31:0] seq_w;
    int          nv;
    bit          exp_frdy;

    initial begin
        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        f3_vld = 1'b0; f3_pld = '0; fl3 = 1'b0; d3_rdy = 1'b0;

        // {vld, base, flush, rdy | cnt, dec_vld, lane0, lane1, filter_rdy}
        vecs[0]  = '{1'b0, 32'h0,  1'b0, 1'b0, 5'd0, 2'b00, 32'h0,  32'h0,  1'b1};
        vecs[1]  = '{1'b1, 32'h0,  1'b0, 1'b1, 5'd0, 2'b00, 32'h0,  32'h0,  1'b1};
        vecs[2]  = '{1'b0, 32'h0,  1'b0, 1'b1, 5'd4, 2'b11, 32'h11, 32'h22, 1'b1};
        vecs[3]  = '{1'b0, 32'h0,  1'b0, 1'b1, 5'd2, 2'b11, 32'h33, 32'h44, 1'b1};
        vecs[4]  = '{1'b0, 32'h0,  1'b0, 1'b0, 5'd0, 2'b00, 32'h0,  32'h0,  1'b1};
        vecs[5]  = '{1'b1, 32'hA0, 1'b0, 1'b0, 5'd0, 2'b00, 32'h0,  32'h0,  1'b1};
        vecs[6]  = '{1'b1, 32'hB0, 1'b0, 1'b1, 5'd4, 2'b11, 32'hA0, 32'hA1, 1'b1};
        vecs[7]  = '{1'b1, 32'hC0, 1'b1, 1'b1, 5'd6, 2'b00, 32'h0,  32'h0,  1'b0};
        vecs[8]  = '{1'b1, 32'hD0, 1'b0, 1'b0, 5'd0, 2'b00, 32'h0,  32'h0,  1'b1};
        vecs[9]  = '{1'b0, 32'h0,  1'b0, 1'b1, 5'd4, 2'b11, 32'hD0, 32'hD1, 1'b1};
        vecs[10] = '{1'b0, 32'h0,  1'b0, 1'b1, 5'd2, 2'b11, 32'hD2, 32'hD3, 1'b1};
        vecs[11] = '{1'b0, 32'h0,  1'b0, 1'b0, 5'd0, 2'b00, 32'h0,  32'h0,  1'b1};

        #2;
        chk("reset cnt", 64'(ibuf_cnt), 64'd0);
        chk("reset dec_vld", 64'(dec_vld), 64'd0);
        chk("reset filter_rdy", 64'(filter_rdy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Single packet and flush vectors.
        for (int i = 0; i < 12; i++) begin
            if (i == 1) drive(1'b1, {32'h44, 32'h33, 32'h22, 32'h11}, 1'b0, 1'b1);
            else drive(vecs[i].vld, pkt(vecs[i].base), vecs[i].flush, vecs[i].rdy);
            #1;
            chk($sformatf("vec%0d cnt", i), 64'(ibuf_cnt), 64'(vecs[i].cnt));
            chk($sformatf("vec%0d dec_vld", i), 64'(dec_vld), 64'(vecs[i].dvld));
            chk($sformatf("vec%0d filter_rdy", i), 64'(filter_rdy), 64'(vecs[i].frdy));
            if (vecs[i].dvld[0]) chk($sformatf("vec%0d lane0", i), 64'(dec_inst[31:0]), 64'(vecs[i].l0));
            if (vecs[i].dvld[1]) chk($sformatf("vec%0d lane1", i), 64'(dec_inst[63:32]), 64'(vecs[i].l1));
            tick();
        end

        // Fill with decode stalled, then release two cycles.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, pkt(32'h200 + 32'(4 * i)), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, pkt(32'h300), 1'b0, 1'b0);
        #1;
        chk("fill cnt16", 64'(ibuf_cnt), 64'd16);
        chk("fill rdy at 16", 64'(filter_rdy), 64'd0);
        chk("fill lane0", 64'(dec_inst[31:0]), 64'h200);
        dec_rdy = 1'b1;
        tick();
        #1;
        chk("fill cnt14", 64'(ibuf_cnt), 64'd14);
        chk("fill rdy at 14", 64'(filter_rdy), 64'd0);
        chk("fill lane0 after pop", 64'(dec_inst[31:0]), 64'h202);
        tick();
        filter_vld = 1'b0;
        #1;
        chk("fill cnt12", 64'(ibuf_cnt), 64'd12);
        chk("fill rdy at 12", 64'(filter_rdy), 64'd1);
        for (int i = 0; i < 6; i++) tick();
        #1;
        chk("fill drained", 64'(ibuf_cnt), 64'd0);

        // Steady streaming across many wraps against a queue model.
        q.delete();
        seq_w = 32'h1000;
        for (int c = 0; c < 130; c++) begin
            drive(c < 120, pkt(seq_w), 1'b0, 1'b1);
            #1;
            exp_frdy = (16 - q.size()) >= 4;
            nv = (q.size() >= 2) ? 2 : q.size();
            chk("stream cnt", 64'(ibuf_cnt), 64'(q.size()));
            chk("stream filter_rdy", 64'(filter_rdy), 64'(exp_frdy));
            chk("stream dec_vld", 64'(dec_vld), (nv == 2) ? 64'd3 : 64'(nv));
            if (nv > 0) chk("stream lane0", 64'(dec_inst[31:0]), 64'(q[0]));
            if (nv > 1) chk("stream lane1", 64'(dec_inst[63:32]), 64'(q[1]));
            tick();
            for (int k = 0; k < nv; k++) void'(q.pop_front());
            if (filter_vld && exp_frdy) begin
                for (int k = 0; k < 4; k++) q.push_back(seq_w + 32'(k));
                seq_w = seq_w + 32'd4;
            end
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        #1;
        chk("stream drained", 64'(q.size()), 64'd0);
        chk("stream final cnt", 64'(ibuf_cnt), 64'd0);

        // Odd occupancy on the three-lane instance.
        f3_vld = 1'b1; f3_pld = pkt(32'h51); d3_rdy = 1'b0;
        tick();
        f3_vld = 1'b0; d3_rdy = 1'b1;
        #1;
        chk("odd cnt4", 64'(cnt3), 64'd4);
        chk("odd vld3", 64'(d3_vld), 64'd7);
        chk("odd lane2", 64'(d3_inst[95:64]), 64'h53);
        tick();
        f3_vld = 1'b1; f3_pld = pkt(32'h61); d3_rdy = 1'b1;
        #1;
        chk("odd cnt1", 64'(cnt3), 64'd1);
        chk("odd vld1", 64'(d3_vld), 64'd1);
        chk("odd lane0 old", 64'(d3_inst[31:0]), 64'h54);
        chk("odd rdy", 64'(f3_rdy), 64'd1);
        tick();
        f3_vld = 1'b0; d3_rdy = 1'b0;
        #1;
        chk("odd cnt after", 64'(cnt3), 64'd4);
        chk("odd lane0 new", 64'(d3_inst[31:0]), 64'h61);

        // Reset mid-stream at cnt 10.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, pkt(32'h400 + 32'(4 * i)), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        tick();
        drive(1'b1, pkt(32'h500), 1'b0, 1'b1);
        #1;
        chk("pre-reset cnt", 64'(ibuf_cnt), 64'd10);
        rst = 1'b1;
        #1;
        chk("async reset cnt", 64'(ibuf_cnt), 64'd0);
        chk("async reset dec_vld", 64'(dec_vld), 64'd0);
        chk("async reset filter_rdy", 64'(filter_rdy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        tick();
        chk("post-reset rdy", 64'(filter_rdy), 64'd1);
        chk("post-reset cnt", 64'(ibuf_cnt), 64'd0);
        drive(1'b1, pkt(32'h70), 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        #1;
        chk("resume cnt", 64'(ibuf_cnt), 64'd4);
        chk("resume lane0", 64'(dec_inst[31:0]), 64'h70);
        chk("resume lane1", 64'(dec_inst[63:32]), 64'h71);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
